// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FSM sequencer for the 4-bit-opcode MIPS-subset datapath
// Shared instruction/data memory port, retired-instruction counter, illegal-opcode flag.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retire_count,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEMACC, WB, BRANCH, BAD} state_t;
  state_t     cur, nxt;
  logic [3:0] op_q;
  logic       is_lw, is_sw, is_r, uses_imm;
  logic [2:0] alu_fn;
  assign state    = cur;
  assign is_lw    = op_q == 4'd5;
  assign is_sw    = op_q == 4'd6;
  assign is_r     = op_q <= 4'd3 || op_q == 4'd7;
  assign uses_imm = op_q >= 4'd4 && op_q <= 4'd6;
  assign alu_fn   = op_q == 4'd1 ? 3'b110 :
                    op_q == 4'd2 ? 3'b000 :
                    op_q == 4'd3 ? 3'b001 :
                    op_q == 4'd7 ? 3'b111 : 3'b010;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur          <= IDLE;
      op_q         <= '0;
      retire_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op_q <= op;
      if (instr_done) retire_count <= retire_count + 1'b1;
    end
  always_comb begin
    nxt        = cur;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b010;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (cur)
      IDLE: begin
        alu_op = 3'b000;
        nxt    = FETCH;
      end
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nxt      = mem_ready ? DECODE : FETCH;
      end
      // decode looks at the live opcode; op_q only becomes valid afterwards
      DECODE: begin
        pc_write   = op == 4'd10;
        pc_src     = op == 4'd10 ? 2'd2 : 2'd0;
        instr_done = op == 4'd10;
        illegal_op = op > 4'd10;
        nxt        = op <= 4'd7 ? EXEC : op <= 4'd9 ? BRANCH : FETCH;
      end
      EXEC: begin
        alu_op  = alu_fn;
        alu_src = uses_imm;
        nxt     = (is_lw || is_sw) ? MEMACC : WB;
      end
      MEMACC: begin
        iord       = 1'b1;
        alu_src    = 1'b1;
        mem_read   = is_lw;
        mem_write  = is_sw;
        instr_done = mem_ready && is_sw;
        nxt        = !mem_ready ? MEMACC : is_sw ? FETCH : WB;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        alu_src    = uses_imm;
        alu_op     = alu_fn;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        alu_op     = 3'b110;
        pc_write   = (op_q == 4'd8 && zero) || (op_q == 4'd9 && !zero);
        pc_src     = pc_write ? 2'd1 : 2'd0;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      default: begin
        alu_op = 3'b000;
        nxt    = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
// A second, 2-bit-counter instance shares all inputs so counter wrap is seen in a few retires.
module tb_multicycle_control;
  logic        clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [3:0]  op = 4'd0;
  logic        pc_write, ir_write, iord, mem_read, mem_write, alu_src;
  logic        reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op, state;
  logic [15:0] retire_count;
  logic        s_pc_write, s_ir_write, s_iord, s_mem_read, s_mem_write, s_alu_src;
  logic        s_reg_write, s_reg_dst, s_mem_to_reg, s_instr_done, s_illegal_op;
  logic [1:0]  s_pc_src, s_retire_count;
  logic [2:0]  s_alu_op, s_state;
  logic [15:0] outs;
  int          errors = 0, checks = 0, exp_cnt = 0;

  assign outs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_src,
                 alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op};

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal_op(illegal_op), .retire_count(retire_count),
    .state(state)
  );

  multicycle_control #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .pc_src(s_pc_src), .ir_write(s_ir_write), .iord(s_iord),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .alu_src(s_alu_src), .alu_op(s_alu_op),
    .reg_write(s_reg_write), .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg),
    .instr_done(s_instr_done), .illegal_op(s_illegal_op), .retire_count(s_retire_count),
    .state(s_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, "_cnt"}, retire_count, exp_cnt[15:0]);
    chk({tag, "_cnt2"}, s_retire_count, exp_cnt[1:0]);
  endtask

  // starts in FETCH; returns in the cycle instr_done is seen, n = cycles from FETCH entry
  task automatic run_instr(input logic [3:0] o, input logic z, output int n);
    op = o;
    zero = z;
    mem_ready = 1'b1;
    #1;
    n = 1;
    while (!instr_done && n < 40) begin
      tick;
      #1;
      n++;
    end
  endtask

  task automatic finish_instr(input string tag);
    exp_cnt++;
    tick;
    #1;
    chk({tag, "_next"}, state, 3'd1);
    check_cnt(tag);
  endtask

  logic [3:0] t_op [5]  = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd4};
  logic [2:0] t_alu [5] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
  logic       t_dst [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       t_src [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    #12;
    chk("rst_outs", outs, 16'd0);
    chk("rst_state", state, 3'd0);
    check_cnt("rst");
    rst_n = 1'b1;
    #1;
    chk("idle_state", state, 3'd0);
    chk("idle_outs", outs, 16'd0);
    tick;
    op = 4'd0;
    #1;
    chk("add_fetch", {state, ir_write, pc_write, pc_src, mem_read, iord}, {3'd1, 6'b110010});
    tick; #1;
    chk("add_decode", state, 3'd2);
    tick; #1;
    chk("add_exec", {state, alu_op}, {3'd3, 3'b010});
    tick; #1;
    chk("add_wb", {state, reg_write, reg_dst, mem_to_reg, instr_done, alu_op}, {3'd5, 7'b1101010});
    finish_instr("add");
    op = 4'd5;
    mem_ready = 1'b0;
    #1;
    chk("lw_fwait", {state, ir_write, mem_read}, {3'd1, 2'b01});
    tick; tick; tick;
    mem_ready = 1'b1;
    #1;
    chk("lw_fgo", {state, ir_write, mem_read}, {3'd1, 2'b11});
    tick; #1;
    chk("lw_decode", state, 3'd2);
    tick; #1;
    chk("lw_exec", {state, alu_src, alu_op}, {3'd3, 1'b1, 3'b010});
    tick;
    mem_ready = 1'b0;
    #1;
    chk("lw_mem", {state, mem_read, mem_write, iord, instr_done}, {3'd4, 4'b1010});
    tick; #1;
    chk("lw_mem_hold", {state, mem_read}, {3'd4, 1'b1});
    tick;
    mem_ready = 1'b1;
    #1;
    chk("lw_mem_go", {state, mem_read, instr_done}, {3'd4, 2'b10});
    tick; #1;
    chk("lw_wb", {state, instr_done, reg_write, mem_to_reg, reg_dst}, {3'd5, 4'b1110});
    finish_instr("lw");
    run_instr(4'd8, 1'b1, n);
    chk("beq_lat", n, 3);
    chk("beq_ctl", {state, pc_write, pc_src, alu_op, alu_src}, {3'd6, 1'b1, 2'd1, 3'b110, 1'b0});
    finish_instr("beq");
    run_instr(4'd9, 1'b1, n);
    chk("bne_nt_lat", n, 3);
    chk("bne_nt_ctl", {pc_write, instr_done}, 2'b01);
    finish_instr("bne_nt");
    run_instr(4'd9, 1'b0, n);
    chk("bne_t_ctl", {pc_write, pc_src}, 3'b101);
    finish_instr("bne_t");
    run_instr(4'd10, 1'b0, n);
    chk("jmp_lat", n, 2);
    chk("jmp_ctl", {state, pc_write, pc_src, instr_done}, {3'd2, 1'b1, 2'd2, 1'b1});
    finish_instr("jmp");
    op = 4'd15;
    tick; #1;
    chk("ill_decode", {state, illegal_op, instr_done, pc_write}, {3'd2, 3'b100});
    tick; #1;
    chk("ill_next", state, 3'd1);
    check_cnt("ill");
    for (int i = 0; i < 5; i++) begin
      run_instr(t_op[i], 1'b0, n);
      chk($sformatf("alu%0d_lat", i), n, 4);
      chk($sformatf("alu%0d_wb", i), {alu_op, alu_src, reg_dst, mem_to_reg, state},
          {t_alu[i], t_src[i], t_dst[i], 1'b0, 3'd5});
      finish_instr($sformatf("alu%0d", i));
    end
    run_instr(4'd6, 1'b0, n);
    chk("sw_lat", n, 4);
    chk("sw_ctl", {state, mem_write, mem_read, iord, instr_done}, {3'd4, 4'b1011});
    finish_instr("sw");
    op = 4'd6;
    tick; tick; tick;
    mem_ready = 1'b0;
    #1;
    chk("abort_pre", {state, mem_write, instr_done}, {3'd4, 2'b10});
    rst_n = 1'b0;
    #1;
    chk("abort_outs", outs, 16'd0);
    chk("abort_state", state, 3'd0);
    exp_cnt = 0;
    check_cnt("abort");
    mem_ready = 1'b1;
    tick; #1;
    chk("abort_held", {state, outs}, 19'd0);
    rst_n = 1'b1;
    #1;
    chk("restart_idle", state, 3'd0);
    tick; #1;
    chk("restart_fetch", state, 3'd1);
    run_instr(4'd0, 1'b0, n);
    chk("add2_lat", n, 4);
    finish_instr("add2");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
